pop_scan_sequencer: RTL and testbench
=====================================

// Module: pop_scan_sequencer
// PURPOSE
//  Automated Ramsey scan controller for the POP timing generator. Replaces manual
//  freeprecess_plus button presses: restores defaults, then steps the free-precession
//  time NUM_STEPS times, holding each value for SETTLE + CYCLES_PER_STEP POP cycles.
//  Gates the optical sample window so downstream capture only sees settled cycles.
//  Sits between the front-panel/host control logic and the POP timer block.
// PARAMETERS
//  NUM_STEPS        16  free-precession values per scan (>=1)
//  CYCLES_PER_STEP  64  POP cycles acquired per step (>=1)
//  SETTLE_CYCLES     2  POP cycles discarded after each step change (0 = none)
//  LOAD_LEN          4  clocks load_defaults is held high (>=1)
//  STEP_W            8  width of step_index (2**STEP_W >= NUM_STEPS)
//  CNT_W            16  width of the internal POP-cycle counter
// PORTS
//  clk_2M5           in   1       2.5MHz system clock
//  reset_n           in   1       async active-low reset
//  start             in   1       level; sampled in IDLE only
//  abort             in   1       level; terminates scan from any non-IDLE state
//  pump              in   1       pump output of POP timer (cycle marker)
//  sample            in   1       sample output of POP timer
//  load_defaults     out  1       to POP timer; resets counter and adjustable values
//  freeprecess_plus  out  1       to POP timer; one-clock increment pulse
//  sample_valid      out  1       sample & (state==ACQUIRE)
//  busy              out  1       high in every state except IDLE
//  done              out  1       one-clock pulse on normal scan completion
//  step_index        out  STEP_W  current step, 0..NUM_STEPS-1
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0, pump_q 0.
//  Cycle marker: pump_q <= pump every clock; pump_rise = pump & ~pump_q
//   (one clock after pump rises). Every POP-cycle count increments on pump_rise only.
//  States:
//   IDLE    start=1 -> LOAD; step_index <= 0.
//   LOAD    load_defaults=1 for exactly LOAD_LEN clocks -> SYNC.
//   SYNC    wait for first pump_rise -> SETTLE (or ACQUIRE if SETTLE_CYCLES==0);
//           cnt <= 0. This first pump_rise is not counted.
//   SETTLE  cnt++ on pump_rise; on pump_rise with cnt==SETTLE_CYCLES-1 -> ACQUIRE,
//           cnt <= 0.
//   ACQUIRE cnt++ on pump_rise; on pump_rise with cnt==CYCLES_PER_STEP-1:
//           step_index==NUM_STEPS-1 -> FINISH with done_pend=1; else -> STEP.
//   STEP    freeprecess_plus=1 for one clock; step_index++ ; cnt <= 0;
//           -> SETTLE (or ACQUIRE if SETTLE_CYCLES==0).
//   FINISH  load_defaults=1 for LOAD_LEN clocks; on exit -> IDLE, done=1 for one
//           clock if done_pend, done_pend cleared.
//  Increment lands one clock after a pump rise, i.e. during the pump pulse, before any
//   MW threshold of that cycle is reached; the whole cycle uses the new value.
//  abort (any state except IDLE and FINISH) -> FINISH with done_pend=0; abort in
//   IDLE or FINISH has no effect. abort has priority over start and all counting.
//  start while busy is ignored; start held high re-launches a scan from IDLE the
//   clock after done.
//  Counters never wrap: SETTLE/ACQUIRE counts compare with ==; step_index stays
//   <= NUM_STEPS-1. No freeprecess_plus after the final step.
//  Total freeprecess_plus pulses per complete scan = NUM_STEPS-1.
//  pump stuck low: sequencer waits indefinitely in SYNC/SETTLE/ACQUIRE; abort recovers.
//  Outputs registered (Moore); sample_valid is the only combinational output.
//  reset_n asserted mid-scan: immediate IDLE, load_defaults/freeprecess_plus drop to 0.
// TESTING
//  1 NUM_STEPS=3,CYCLES_PER_STEP=4,SETTLE=2, pump model 1-in-20 clk, start pulse ->
//    load_defaults 4 clk, exactly 2 freeprecess_plus pulses, each 6 pump rises apart,
//    done once after 4 acquire rises of step 2, busy low after done.
//  2 SETTLE_CYCLES=0 -> STEP goes straight to ACQUIRE; sample_valid high on first
//    sample window after each increment.
//  3 abort asserted during step 1 ACQUIRE -> FINISH, load_defaults 4 clk, done never
//    pulses, step_index resets to 0 on next start.
//  4 start held high continuously, NUM_STEPS=1 -> zero freeprecess_plus pulses, done
//    pulses, new LOAD begins the next clock.
//  5 reset_n low mid-STEP (freeprecess_plus=1) -> all outputs 0 asynchronously;
//    reset_n high with start=0 -> stays IDLE, busy=0.
//  6 pump stuck low after SYNC -> no counter progress over 10000 clk; abort -> IDLE.

Source files
------------

// File: rtl/pop_scan_sequencer.sv
// Ramsey scan controller for the POP timer: restores defaults, then steps the
// free-precession time and gates the sample window to settled cycles only.
module pop_scan_sequencer #(
  parameter int NUM_STEPS       = 16,
  parameter int CYCLES_PER_STEP = 64,
  parameter int SETTLE_CYCLES   = 2,
  parameter int LOAD_LEN        = 4,
  parameter int STEP_W          = 8,
  parameter int CNT_W           = 16
) (
  input  logic              clk_2M5,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              pump,
  input  logic              sample,
  output logic              load_defaults,
  output logic              freeprecess_plus,
  output logic              sample_valid,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] step_index
);

  typedef enum logic [2:0] {
    IDLE, LOAD, SYNC, SETTLE, ACQUIRE, STEP, FINISH
  } state_t;

  localparam int LW = $clog2(LOAD_LEN + 1);
  localparam logic [LW-1:0] LOAD_LAST =
    LW'(LOAD_LEN - 1);
  localparam logic [CNT_W-1:0] SET_LAST =
    CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] ACQ_LAST =
    CNT_W'(CYCLES_PER_STEP - 1);
  localparam logic [STEP_W-1:0] STEP_LAST =
    STEP_W'(NUM_STEPS - 1);
  localparam state_t AFTER_STEP =
    (SETTLE_CYCLES == 0) ? ACQUIRE : SETTLE;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [LW-1:0]    lcnt;
  logic             pump_q;
  logic             pump_rise;
  logic             done_pend;
  logic             can_abort;

  assign pump_rise    = pump & ~pump_q;
  assign sample_valid = sample & (state == ACQUIRE);
  assign can_abort    = (state != IDLE) && (state != FINISH);

  always_ff @(posedge clk_2M5 or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      cnt              <= '0;
      lcnt             <= '0;
      pump_q           <= 1'b0;
      done_pend        <= 1'b0;
      load_defaults    <= 1'b0;
      freeprecess_plus <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      step_index       <= '0;
    end else begin
      pump_q <= pump;
      done   <= 1'b0;
      if (abort && can_abort) begin
        state            <= FINISH;
        done_pend        <= 1'b0;
        load_defaults    <= 1'b1;
        freeprecess_plus <= 1'b0;
        lcnt             <= '0;
      end else begin
        unique case (state)
          IDLE: if (start) begin
            state         <= LOAD;
            step_index    <= '0;
            load_defaults <= 1'b1;
            lcnt          <= '0;
            busy          <= 1'b1;
          end
          LOAD: begin
            if (lcnt == LOAD_LAST) begin
              state         <= SYNC;
              load_defaults <= 1'b0;
            end else begin
              lcnt <= lcnt + 1'b1;
            end
          end
          SYNC: if (pump_rise) begin
            state <= AFTER_STEP;
            cnt   <= '0;
          end
          SETTLE: if (pump_rise) begin
            if (cnt == SET_LAST) begin
              state <= ACQUIRE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ACQUIRE: if (pump_rise) begin
            if (cnt == ACQ_LAST) begin
              cnt <= '0;
              // last step finishes without a further increment
              if (step_index == STEP_LAST) begin
                state         <= FINISH;
                done_pend     <= 1'b1;
                load_defaults <= 1'b1;
                lcnt          <= '0;
              end else begin
                state            <= STEP;
                freeprecess_plus <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          STEP: begin
            freeprecess_plus <= 1'b0;
            step_index       <= step_index + 1'b1;
            cnt              <= '0;
            state            <= AFTER_STEP;
          end
          FINISH: begin
            if (lcnt == LOAD_LAST) begin
              state         <= IDLE;
              load_defaults <= 1'b0;
              busy          <= 1'b0;
              done          <= done_pend;
              done_pend     <= 1'b0;
            end else begin
              lcnt <= lcnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pop_scan_sequencer.sv
// Scoreboard bench: three sequencer configurations share one POP timer model;
// expected events are queued at stimulus time and matched by a negedge monitor.
`timescale 1ns/1ps
module tb_pop_scan_sequencer;

  localparam int SW   = 8;
  localparam int LS   = 0;
  localparam int LE   = 1;
  localparam int FPP  = 2;
  localparam int DONE = 3;

  typedef struct {
    int k;
    int a;
    int r;
    int w;
    int s;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          pump = 1'b0;
  logic          sample = 1'b0;
  logic          pump_en = 1'b1;
  logic [2:0]    start = '0;
  logic [2:0]    abort = '0;
  logic [2:0]    ld, fp, dn, sv, bz;
  logic [SW-1:0] si [3];

  ev_t q0[$], q1[$], q2[$];
  int  n_chk = 0;
  int  n_fail = 0;
  int  ev_cnt [3];
  int  len [3], rises [3], wins [3];
  logic [2:0] p_ld, p_fp, p_dn, p_sv;
  logic       p_pump;

  always #200 clk = ~clk;

  pop_scan_sequencer #(.NUM_STEPS(3), .CYCLES_PER_STEP(4),
    .SETTLE_CYCLES(2), .LOAD_LEN(4), .STEP_W(SW), .CNT_W(16)) u_a (
    .clk_2M5(clk), .reset_n(reset_n), .start(start[0]),
    .abort(abort[0]), .pump(pump), .sample(sample),
    .load_defaults(ld[0]), .freeprecess_plus(fp[0]),
    .sample_valid(sv[0]), .busy(bz[0]), .done(dn[0]),
    .step_index(si[0]));

  pop_scan_sequencer #(.NUM_STEPS(2), .CYCLES_PER_STEP(3),
    .SETTLE_CYCLES(0), .LOAD_LEN(4), .STEP_W(SW), .CNT_W(16)) u_b (
    .clk_2M5(clk), .reset_n(reset_n), .start(start[1]),
    .abort(abort[1]), .pump(pump), .sample(sample),
    .load_defaults(ld[1]), .freeprecess_plus(fp[1]),
    .sample_valid(sv[1]), .busy(bz[1]), .done(dn[1]),
    .step_index(si[1]));

  pop_scan_sequencer #(.NUM_STEPS(1), .CYCLES_PER_STEP(2),
    .SETTLE_CYCLES(1), .LOAD_LEN(4), .STEP_W(SW), .CNT_W(16)) u_c (
    .clk_2M5(clk), .reset_n(reset_n), .start(start[2]),
    .abort(abort[2]), .pump(pump), .sample(sample),
    .load_defaults(ld[2]), .freeprecess_plus(fp[2]),
    .sample_valid(sv[2]), .busy(bz[2]), .done(dn[2]),
    .step_index(si[2]));

  function automatic int p_num(int i);
    case (i) 0: return 3; 1: return 2; default: return 1; endcase
  endfunction
  function automatic int p_cps(int i);
    case (i) 0: return 4; 1: return 3; default: return 2; endcase
  endfunction
  function automatic int p_set(int i);
    case (i) 0: return 2; 1: return 0; default: return 1; endcase
  endfunction

  task automatic chk(string nm, int got, int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, got, exp);
    end
  endtask

  task automatic push(int i, int k, int a, int r, int w, int s);
    ev_t e;
    e = '{k, a, r, w, s};
    case (i)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // A full scan as seen from outside: pump rises and sample windows
  // between consecutive control events.
  task automatic push_scan(int i);
    int n, c, s;
    n = p_num(i);
    c = p_cps(i);
    s = p_set(i);
    push(i, LS, -1, -1, -1, -1);
    push(i, LE, 4, -1, -1, -1);
    for (int k = 0; k < n - 1; k++)
      push(i, FPP, -1, ((k == 0) ? 1 : 0) + s + c, c, -1);
    push(i, LS, -1, ((n == 1) ? 1 : 0) + s + c, c, -1);
    push(i, LE, 4, -1, -1, -1);
    push(i, DONE, -1, 0, 0, n - 1);
  endtask

  task automatic got(int i, int k, int a, int r, int w, int s);
    ev_t e;
    bit  have;
    have = 1'b0;
    ev_cnt[i]++;
    case (i)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default:
        if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    n_chk++;
    if (!have) begin
      n_fail++;
      $display("FAIL event inst%0d: got kind=%0d len=%0d rises=%0d wins=%0d step=%0d, required none",
               i, k, a, r, w, s);
    end else if (e.k != k || (e.a >= 0 && e.a != a) ||
                 (e.r >= 0 && e.r != r) || (e.w >= 0 && e.w != w) ||
                 (e.s >= 0 && e.s != s)) begin
      n_fail++;
      $display("FAIL event inst%0d: got kind=%0d len=%0d rises=%0d wins=%0d step=%0d, required kind=%0d len=%0d rises=%0d wins=%0d step=%0d",
               i, k, a, r, w, s, e.k, e.a, e.r, e.w, e.s);
    end
  endtask

  task automatic mon(int i, bit rise);
    if (ld[i] && !p_ld[i]) begin
      got(i, LS, 0, rises[i], wins[i], int'(si[i]));
      rises[i] = 0; wins[i] = 0; len[i] = 0;
    end
    if (ld[i]) len[i]++;
    if (!ld[i] && p_ld[i]) begin
      got(i, LE, len[i], rises[i], wins[i], int'(si[i]));
      rises[i] = 0; wins[i] = 0;
    end
    if (fp[i]) begin
      chk("fpp pulse width", int'(p_fp[i]), 0);
      got(i, FPP, 0, rises[i], wins[i], int'(si[i]));
      rises[i] = 0; wins[i] = 0;
    end
    if (dn[i]) begin
      chk("done pulse width", int'(p_dn[i]), 0);
      got(i, DONE, 0, rises[i], wins[i], int'(si[i]));
      rises[i] = 0; wins[i] = 0;
    end
    if (rise) rises[i]++;
    if (sv[i] && !p_sv[i]) wins[i]++;
    p_ld[i] = ld[i];
    p_fp[i] = fp[i];
    p_dn[i] = dn[i];
    p_sv[i] = sv[i];
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      ev_cnt[i] = 0; len[i] = 0; rises[i] = 0; wins[i] = 0;
    end
    p_ld = '0; p_fp = '0; p_dn = '0; p_sv = '0; p_pump = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        p_ld = '0; p_fp = '0; p_dn = '0; p_sv = '0;
        for (int i = 0; i < 3; i++) begin
          len[i] = 0; rises[i] = 0; wins[i] = 0;
        end
      end else begin
        for (int i = 0; i < 3; i++) mon(i, pump & ~p_pump);
      end
      p_pump = pump;
    end
  end

  // POP timer model: 20-clock cycle, pump at phases 0..2, sample at 10..11
  initial begin
    int phase;
    phase = 5;
    forever begin
      @(posedge clk);
      #1;
      phase  = (phase == 19) ? 0 : phase + 1;
      pump   = pump_en && (phase < 3);
      sample = (phase >= 10) && (phase <= 11);
    end
  end

  task automatic at_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(int i);
    at_tick();
    start[i] = 1'b1;
    at_tick();
    start[i] = 1'b0;
  endtask

  task automatic wait_done(int i, int lim);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!dn[i] && k < lim);
    chk("done reached", int'(dn[i]), 1);
  endtask

  task automatic wait_fp(int i, int lim);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!fp[i] && k < lim);
    chk("fpp reached", int'(fp[i]), 1);
  endtask

  task automatic wait_idle(int i, int lim);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bz[i] && k < lim);
    chk("idle reached", int'(bz[i]), 0);
  endtask

  initial begin
    int e0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset ctrl outs", int'({ld[i], fp[i], dn[i], bz[i]}), 0);
      chk("reset step_index", int'(si[i]), 0);
    end
    at_tick();
    reset_n = 1'b1;

    // full scan, settle 2
    push_scan(0);
    pulse(0);
    wait_done(0, 3000);
    chk("busy at done", int'(bz[0]), 0);
    @(negedge clk);
    chk("no relaunch", int'({ld[0], bz[0]}), 0);

    // settle 0: straight into acquire after each step
    push_scan(1);
    pulse(1);
    wait_done(1, 3000);
    chk("busy at done b", int'(bz[1]), 0);

    // abort during step 1 acquire
    push(0, LS, -1, -1, -1, -1);
    push(0, LE, 4, -1, -1, -1);
    push(0, FPP, -1, 7, 4, -1);
    push(0, LS, -1, -1, -1, -1);
    push(0, LE, 4, -1, -1, -1);
    pulse(0);
    wait_fp(0, 3000);
    repeat (4) @(posedge pump);
    repeat (3) @(posedge clk);
    at_tick();
    abort[0] = 1'b1;
    at_tick();
    abort[0] = 1'b0;
    wait_idle(0, 100);
    repeat (40) @(negedge clk);
    push_scan(0);
    pulse(0);
    @(negedge clk);
    chk("restart step_index", int'(si[0]), 0);
    chk("restart load", int'(ld[0]), 1);
    wait_done(0, 3000);

    // start held high with a single step
    push_scan(2);
    push_scan(2);
    at_tick();
    start[2] = 1'b1;
    wait_done(2, 3000);
    @(negedge clk);
    chk("relaunch load", int'(ld[2]), 1);
    wait_done(2, 3000);
    start[2] = 1'b0;
    repeat (3) @(negedge clk);
    chk("held start stop", int'(bz[2]), 0);

    // async reset while the increment pulse is high
    push_scan(0);
    pulse(0);
    wait_fp(0, 3000);
    #50;
    reset_n = 1'b0;
    #1;
    chk("async reset outs", int'({ld[0], fp[0], dn[0], bz[0]}), 0);
    chk("async reset step", int'(si[0]), 0);
    q0.delete();
    repeat (3) at_tick();
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle after reset", int'({ld[0], bz[0]}), 0);

    // pump stuck low, then abort
    push(0, LS, -1, -1, -1, -1);
    push(0, LE, 4, -1, -1, -1);
    push(0, LS, -1, -1, -1, -1);
    push(0, LE, 4, -1, -1, -1);
    pulse(0);
    begin
      int k;
      k = 0;
      while (ld[0] && k < 50) begin
        @(negedge clk);
        k++;
      end
      chk("load ended", int'(ld[0]), 0);
    end
    repeat (2) @(posedge pump);
    pump_en = 1'b0;
    repeat (5) @(negedge clk);
    e0 = ev_cnt[0];
    repeat (10000) @(negedge clk);
    chk("stuck no events", ev_cnt[0], e0);
    chk("stuck busy", int'(bz[0]), 1);
    at_tick();
    abort[0] = 1'b1;
    at_tick();
    abort[0] = 1'b0;
    wait_idle(0, 100);
    pump_en = 1'b1;
    repeat (10) @(negedge clk);

    chk("queue a empty", q0.size(), 0);
    chk("queue b empty", q1.size(), 0);
    chk("queue c empty", q2.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
